// File: rtl/fifo_fwft_reader.sv
// First-word-fall-through read adapter for a FIFO with a fixed-latency RAM.
// It prefetches words into a small circular buffer and presents the head as a
// valid/ready stream. Read requests are credit-limited by buf_level, so a word
// coming back from the RAM always has a free buffer slot waiting for it.
module fifo_fwft_reader #(
    parameter  int DATA_WIDTH = 32,
    parameter  int RD_LATENCY = 2,
    localparam int BUF_DEPTH  = RD_LATENCY + 2
) (
    input  logic                             rclk,
    input  logic                             rrst_n,
    input  logic                             rempty,
    output logic                             r_en,
    input  logic [DATA_WIDTH-1:0]            rdata,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_level
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int LVL_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [LVL_W-1:0]      count_q, count_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [RD_LATENCY-1:0] infl_q, infl_d;

    logic issue;
    logic wr_en;
    logic xfer;

    // Circular pointer increment that wraps at the last buffer entry.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Request and handshake decode; r_en depends only on rempty, flush, reset and the level register.
    always_comb begin
        r_en      = rrst_n && !rempty && !flush && (level_q < FULL_LVL);
        issue     = r_en && !rempty;
        wr_en     = infl_q[RD_LATENCY-1];
        m_valid   = (count_q != '0);
        m_data    = mem_q[head_q];
        xfer      = m_valid && m_ready;
        buf_level = level_q;
    end

    // Next-state for the in-flight tracker, buffer storage, pointers and counters; flush wipes everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        level_d = level_q;
        infl_d  = infl_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            level_d = '0;
            infl_d  = '0;
        end else begin
            infl_d[0] = issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                infl_d[i] = infl_q[i-1];
            end
            if (wr_en) begin
                mem_d[tail_q] = rdata;
                tail_d        = next_ptr(tail_q);
            end
            if (xfer) begin
                head_d = next_ptr(head_q);
            end
            count_d = count_q + LVL_W'(wr_en) - LVL_W'(xfer);
            level_d = level_q + LVL_W'(issue) - LVL_W'(xfer);
        end
    end

    // State registers; reset clears the buffer contents too so m_data reads zero.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            level_q <= '0;
            infl_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            level_q <= level_d;
            infl_q  <= infl_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Self-checking bench for fifo_fwft_reader: one instance with two-cycle RAM
// latency and one with single-cycle latency share reset, rempty, flush and
// m_ready. Each has its own RAM delay-line model and a cycle-level model of the
// expected buffer contents; directed checks pin the hand-computed timings.
module tb_fifo_fwft_reader;

   logic        rclk = 1'b0;
   logic        rrst_n;
   logic        rempty;
   logic        flush;
   logic        m_ready;
   logic        r_en2, r_en1;
   logic        m_valid2, m_valid1;
   logic [31:0] rdata2, rdata1;
   logic [31:0] m_data2, m_data1;
   logic [2:0]  level2;
   logic [1:0]  level1;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;

   // Index 0 models the latency-2 instance, index 1 the latency-1 instance.
   logic [31:0] bufq0[$];
   logic [31:0] bufq1[$];
   logic        pv [2][2];
   logic [31:0] pd [2][2];
   int          srcCnt [2];
   int          xferCnt [2];
   int          issueBase [2];
   logic [31:0] rdyPat;

   fifo_fwft_reader #(.DATA_WIDTH(32), .RD_LATENCY(2)) dutL2 (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .rempty    (rempty),
      .r_en      (r_en2),
      .rdata     (rdata2),
      .flush     (flush),
      .m_valid   (m_valid2),
      .m_ready   (m_ready),
      .m_data    (m_data2),
      .buf_level (level2)
   );

   fifo_fwft_reader #(.DATA_WIDTH(32), .RD_LATENCY(1)) dutL1 (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .rempty    (rempty),
      .r_en      (r_en1),
      .rdata     (rdata1),
      .flush     (flush),
      .m_valid   (m_valid1),
      .m_ready   (m_ready),
      .m_data    (m_data1),
      .buf_level (level1)
   );

   // Free-running read clock, 10 time units per cycle.
   always #5 rclk = ~rclk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic string tagK(input string s, input int k);
      return $sformatf("%s_l%0d", s, (k == 0) ? 2 : 1);
   endfunction

   function automatic logic dutREn(input int k);
      return (k == 0) ? r_en2 : r_en1;
   endfunction

   function automatic logic dutValid(input int k);
      return (k == 0) ? m_valid2 : m_valid1;
   endfunction

   function automatic logic [31:0] dutData(input int k);
      return (k == 0) ? m_data2 : m_data1;
   endfunction

   function automatic logic [2:0] dutLevel(input int k);
      return (k == 0) ? level2 : {1'b0, level1};
   endfunction

   function automatic int bufSize(input int k);
      return (k == 0) ? bufq0.size() : bufq1.size();
   endfunction

   function automatic logic [31:0] bufFront(input int k);
      return (k == 0) ? bufq0[0] : bufq1[0];
   endfunction

   task automatic bufPop(input int k);
      if (k == 0) void'(bufq0.pop_front());
      else        void'(bufq1.pop_front());
   endtask

   task automatic bufPush(input int k, input logic [31:0] w);
      if (k == 0) bufq0.push_back(w);
      else        bufq1.push_back(w);
   endtask

   task automatic bufClear(input int k);
      if (k == 0) bufq0.delete();
      else        bufq1.delete();
   endtask

   task automatic resetSource();
      for (int k = 0; k < 2; k++) begin
         srcCnt[k] = 0;
      end
   endtask

   // Sample the DUTs mid-cycle, compare against the model, then advance the model by one clock.
   task automatic stepCycle();
      int          lat;
      int          depth;
      int          lvl;
      logic        expREn;
      logic        expValid;
      logic        xfer;
      logic [31:0] word;
      #1;
      for (int k = 0; k < 2; k++) begin
         lat   = (k == 0) ? 2 : 1;
         depth = lat + 2;
         if (!rrst_n) begin
            bufClear(k);
            pv[k][0] = 1'b0;
            pv[k][1] = 1'b0;
         end
         lvl      = bufSize(k) + int'(pv[k][0]) + int'(pv[k][1]);
         expValid = (bufSize(k) > 0);
         expREn   = rrst_n && !rempty && !flush && (lvl < depth);
         checkOutput(tagK("r_en", k), 32'(dutREn(k)), 32'(expREn));
         checkOutput(tagK("m_valid", k), 32'(dutValid(k)), 32'(expValid));
         checkOutput(tagK("buf_level", k), 32'(dutLevel(k)), 32'(lvl));
         if (expValid) checkOutput(tagK("m_data", k), dutData(k), bufFront(k));
         if (!rrst_n) checkOutput(tagK("m_data_rst", k), dutData(k), 32'h0);
         if (rrst_n && dutValid(k) && m_ready) xferCnt[k]++;
         if (rrst_n) begin
            xfer = expValid && m_ready;
            if (xfer) bufPop(k);
            if (pv[k][lat-1] && !flush) bufPush(k, pd[k][lat-1]);
            if (flush) bufClear(k);
            if (lat == 2) begin
               pv[k][1] = pv[k][0];
               pd[k][1] = pd[k][0];
            end
            word     = expREn ? (32'h11 * 32'(srcCnt[k] + 1)) : (32'hBAD0_0000 | 32'(cyc));
            pv[k][0] = expREn;
            pd[k][0] = word;
            if (expREn) srcCnt[k]++;
            if (flush) begin
               pv[k][0] = 1'b0;
               pv[k][1] = 1'b0;
            end
         end
      end
   endtask

   // Move to the next falling edge, present RAM data for this cycle, drive inputs and check.
   task automatic applyStimulus(input logic rstV, input logic emptyV, input logic flushV, input logic readyV);
      @(negedge rclk);
      cyc++;
      rdata2  = pd[0][1];
      rdata1  = pd[1][0];
      rrst_n  = rstV;
      rempty  = emptyV;
      flush   = flushV;
      m_ready = readyV;
      stepCycle();
   endtask

   initial begin
      rrst_n  = 1'b0;
      rempty  = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b1;
      rdata2  = '0;
      rdata1  = '0;
      rdyPat  = 32'hB2E5_3D8D;
      for (int k = 0; k < 2; k++) begin
         pv[k][0]     = 1'b0;
         pv[k][1]     = 1'b0;
         pd[k][0]     = '0;
         pd[k][1]     = '0;
         srcCnt[k]    = 0;
         xferCnt[k]   = 0;
         issueBase[k] = 0;
      end

      $display("[TB] power-on reset with FIFO non-empty");
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("rst_r_en_l2", 32'(r_en2), 32'h0);
         checkOutput("rst_level_l2", 32'(level2), 32'h0);
      end

      $display("[TB] three-word burst");
      resetSource();
      for (int c = 0; c < 9; c++) begin
         applyStimulus(1'b1, (c >= 3), 1'b0, 1'b1);
         if (c == 2) checkOutput("burst_early_l2", 32'(m_valid2), 32'h0);
         if (c == 3) checkOutput("burst_first_valid_l2", 32'(m_valid2), 32'h1);
         if (c == 3) checkOutput("burst_first_l2", m_data2, 32'h11);
         if (c == 4) checkOutput("burst_second_l2", m_data2, 32'h22);
         if (c == 5) checkOutput("burst_third_l2", m_data2, 32'h33);
         if (c == 6) checkOutput("burst_done_l2", 32'(m_valid2), 32'h0);
         if (c == 1) checkOutput("burst_early_l1", 32'(m_valid1), 32'h0);
         if (c == 2) checkOutput("burst_first_l1", m_data1, 32'h11);
         if (c == 2) checkOutput("burst_first_valid_l1", 32'(m_valid1), 32'h1);
         if (c == 3) checkOutput("burst_second_l1", m_data1, 32'h22);
         if (c == 4) checkOutput("burst_third_l1", m_data1, 32'h33);
         if (c == 5) checkOutput("burst_done_l1", 32'(m_valid1), 32'h0);
      end

      $display("[TB] backpressure then release");
      resetSource();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("bp_level_l2", 32'(level2), 32'd4);
      checkOutput("bp_r_en_l2", 32'(r_en2), 32'h0);
      checkOutput("bp_hold_l2", m_data2, 32'h11);
      checkOutput("bp_level_l1", 32'(level1), 32'd3);
      checkOutput("bp_r_en_l1", 32'(r_en1), 32'h0);
      checkOutput("bp_hold_l1", m_data1, 32'h11);
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
         if (c < 6) begin
            checkOutput("stream_l2", m_data2, 32'h11 * 32'(c + 1));
            checkOutput("stream_l1", m_data1, 32'h11 * 32'(c + 1));
         end
      end
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      end

      $display("[TB] flush with words in flight");
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, (c > 2), (c == 2), 1'b1);
         if (c == 2) checkOutput("flush_r_en_l2", 32'(r_en2), 32'h0);
         if (c == 3) begin
            checkOutput("flush_valid_l2", 32'(m_valid2), 32'h0);
            checkOutput("flush_level_l2", 32'(level2), 32'h0);
            checkOutput("flush_valid_l1", 32'(m_valid1), 32'h0);
            checkOutput("flush_level_l1", 32'(level1), 32'h0);
         end
      end

      $display("[TB] toggling rempty with irregular m_ready");
      for (int k = 0; k < 2; k++) begin
         issueBase[k] = srcCnt[k];
         xferCnt[k]   = 0;
      end
      for (int c = 0; c < 40; c++) begin
         applyStimulus(1'b1, ((c % 2) == 1), 1'b0, rdyPat[c % 32]);
      end
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      end
      checkOutput("toggle_count_l2", 32'(xferCnt[0]), 32'(srcCnt[0] - issueBase[0]));
      checkOutput("toggle_count_l1", 32'(xferCnt[1]), 32'(srcCnt[1] - issueBase[1]));

      $display("[TB] reset pulse mid-stream");
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      end
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("midrst_valid_l2", 32'(m_valid2), 32'h0);
         checkOutput("midrst_level_l2", 32'(level2), 32'h0);
         checkOutput("midrst_r_en_l1", 32'(r_en1), 32'h0);
      end
      resetSource();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, (c >= 3), 1'b0, 1'b1);
         if (c == 0) checkOutput("postrst_quiet_l2", 32'(m_valid2), 32'h0);
         if (c == 3) checkOutput("postrst_first_l2", m_data2, 32'h11);
         if (c == 3) checkOutput("postrst_valid_l2", 32'(m_valid2), 32'h1);
         if (c == 2) checkOutput("postrst_first_l1", m_data1, 32'h11);
         if (c == 2) checkOutput("postrst_valid_l1", 32'(m_valid1), 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fifo_fwft_reader.md
FIFO_FWFT_READER -- requirements
Module: fifo_fwft_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of the RAM read data and output data.
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning RAM read latency in cycles (legal values 1 or 2).
REQ-003 SHALL have localparam BUF_DEPTH = RD_LATENCY+2, meaning prefetch buffer entries.
REQ-004 rclk  input  1  read clock; all logic is in this single clock domain.
REQ-005 rrst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rempty  input  1  FIFO controller read-empty flag.
REQ-007 r_en  output  1  read enable to the FIFO controller.
REQ-008 rdata  input  DATA_WIDTH  RAM read data.
REQ-009 flush  input  1  synchronous discard of buffered and in-flight words.
REQ-010 m_valid  output  1  output word valid.
REQ-011 m_ready  input  1  downstream accept.
REQ-012 m_data  output  DATA_WIDTH  output word (buffer head).
REQ-013 buf_level  output  $clog2(BUF_DEPTH+1)  words in buffer plus words in flight.

Function
REQ-014 An issue SHALL occur in a cycle when r_en=1 and rempty=0; a cycle with r_en=1 and rempty=1 SHALL NOT count as an issue.
REQ-015 r_en SHALL equal !rempty && !flush && (buf_level < BUF_DEPTH), with no combinational path from m_ready or rdata.
REQ-016 Each issue SHALL set a RD_LATENCY-stage in-flight valid shift register; rdata SHALL be written into the buffer tail on the rising edge that ends the cycle RD_LATENCY cycles after the issue cycle.
REQ-017 The buffer SHALL be a circular queue of BUF_DEPTH entries with registered head/tail pointers wrapping modulo BUF_DEPTH.
REQ-018 m_valid SHALL be 1 whenever the buffer holds at least one word, and m_data SHALL be the head entry; first-word latency SHALL be issue cycle T -> m_valid=1 in cycle T+RD_LATENCY+1.
REQ-019 A transfer SHALL occur when m_valid=1 and m_ready=1; the head pointer SHALL advance on that edge.
REQ-020 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 buf_level SHALL update every cycle as buf_level + issue - transfer, including a simultaneous issue and transfer (net 0); it SHALL never exceed BUF_DEPTH.
REQ-022 A write into a full buffer SHALL be impossible by construction, guaranteed by REQ-015 credit accounting.
REQ-023 With rempty=0 and m_ready=1 held, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-024 flush=1 SHALL empty the buffer, clear the in-flight shift register, and set buf_level to 0 on that edge; m_valid SHALL be 0 in the next cycle.
REQ-025 rdata arriving for words issued before the flush SHALL be discarded.
REQ-026 A transfer in the flush cycle SHALL be accepted by downstream but SHALL have no further effect.
REQ-027 rempty rising while words are in flight SHALL NOT cancel those words; they SHALL still be buffered and delivered.
REQ-028 Word order at m_data SHALL equal issue order.

Reset
REQ-029 On rrst_n=0, independent of rclk: m_valid=0, m_data=0, buf_level=0, head/tail=0, and in-flight register=0.
REQ-030 r_en SHALL be 0 while rrst_n=0.
REQ-031 Outputs SHALL remain at reset values until the first rclk edge after rrst_n deasserts.
REQ-032 Reset asserted mid-burst SHALL drop all in-flight words; no stale word SHALL appear after release.

Verification
REQ-033 RD_LATENCY=2, words 0x11,0x22,0x33 available, m_ready=1 -> first issue cycle T, m_data=0x11 with m_valid=1 at T+3, then 0x22 and 0x33 on consecutive cycles, then m_valid=0.
REQ-034 Backpressure: m_ready=0 with the FIFO non-empty -> buf_level saturates at 4, r_en=0, m_data holds the first word; m_ready=1 -> 4 words in order, then streaming resumes.
REQ-035 flush one cycle after two issues (words in flight) -> m_valid=0 next cycle, buf_level=0, and late rdata is never presented.
REQ-036 rempty toggling each cycle with m_ready random -> output sequence equals the scoreboard issue order, with no loss or duplication.
REQ-037 rrst_n pulsed low mid-stream -> all outputs 0 immediately; after release the next delivered word is the first word issued post-reset.
REQ-038 RD_LATENCY=1 rerun of REQ-033 -> first word at T+2, and BUF_DEPTH=3 saturation under backpressure.
